frame_readback_reader: RTL and testbench
========================================

# frame_readback_reader

Read side of the screen-capture path. After a frame has been captured into SDRAM at consecutive word addresses, this block acts as an Avalon-MM read master. It fetches `FRAME_PIXELS` 24-bit pixels in order, buffers them in a small FIFO, and streams them out as bytes over a valid/ready interface to the host link. It replaces Nios-driven pixel-by-pixel reads and signals completion so the capture side can re-arm.

## Interface
- `FRAME_PIXELS`, 307200: pixels per frame (640x480).
- `BASE_ADDR`, 0: first SDRAM word address of the frame.
- `FIFO_DEPTH`, 8: pixel FIFO entries. Power of two, ≥2. Also the cap on outstanding reads.
- `SDRAM_CLK` in 1: block clock. All logic is on this clock.
- `Reset` in 1: reset, asynchronous, active-low.
- `Start` in 1: one-cycle request to begin readback. Honoured only in IDLE or DONE.
- `Avm_ChipSelect` out 1: high whenever state is READ or DRAIN.
- `Avm_Address` out 25: word address of the current read request.
- `Avm_Read_N` out 1: active-low read request.
- `Avm_ByteEnable_N` out 4: constant `4'b1000`, three bytes active.
- `Avm_WaitRequest` in 1: slave stall. A request is accepted on a cycle with `Avm_Read_N`=0 and `Avm_WaitRequest`=0.
- `Avm_ReadData` in 24: returned pixel, `{R,G,B}` in bits `[23:16]`, `[15:8]`, `[7:0]`.
- `Avm_ReadDataValid` in 1: `Avm_ReadData` is valid this cycle. Responses return in request order.
- `Out_Byte` out 8: streamed byte.
- `Out_Valid` out 1: `Out_Byte` is valid.
- `Out_Ready` in 1: sink accepts. A transfer occurs on a cycle with `Out_Valid` and `Out_Ready` both high.
- `Busy` out 1: high in READ and DRAIN.
- `Done` out 1: high in DONE. Held until the next accepted `Start` or reset.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on `Start`.
  - READ -> DRAIN when the request count reaches `FRAME_PIXELS`.
  - DRAIN -> DONE on acceptance of the last byte of the last pixel.
  - DONE -> READ on `Start`.
- On entering READ, clear all counters, the FIFO and the serializer, and set the address register to `BASE_ADDR`.
- Counters:
  - `req_cnt` (19 b): accepted requests.
  - `out_cnt` (19 b): pixels fully emitted.
  - `credit` (log2(FIFO_DEPTH)+1 b): outstanding requests plus FIFO occupancy.
- Request issue (READ only): drive `Avm_Read_N`=0 when `req_cnt` < `FRAME_PIXELS` and `credit` < `FIFO_DEPTH`.
  - While stalled by `Avm_WaitRequest`, hold address and `Avm_Read_N` stable.
  - On acceptance: address +1, `req_cnt` +1, `credit` +1.
- Response: `Avm_ReadDataValid` pushes `Avm_ReadData` into the FIFO. The credit scheme makes overflow impossible. Responses in IDLE or DONE are discarded.
- Serializer: when idle and the FIFO is non-empty, pop one pixel (`credit` -1) and emit bytes in the order R, G, B.
  - `Out_Byte` and `Out_Valid` are held stable until accepted.
  - After the B byte is accepted, `out_cnt` +1. The next pixel may be popped in that same cycle.
- Simultaneous push and pop on one cycle is legal; occupancy is unchanged.
- Simultaneous credit +1 (request accepted) and -1 (pop) in one cycle: `credit` is unchanged.
- `Start` while `Busy`: ignored.
- Reset asserted mid-frame: immediately returns to IDLE with all outputs at reset values. The frame is abandoned.

## Timing
- Reset values: `Avm_ChipSelect`=0, `Avm_Address`=`BASE_ADDR`, `Avm_Read_N`=1, `Out_Valid`=0, `Out_Byte`=0, `Busy`=0, `Done`=0. `Avm_ByteEnable_N` is constant `4'b1000`.
- `Start` seen at edge N: `Busy`, `Avm_ChipSelect` and the first `Avm_Read_N`=0 appear after edge N (registered).
- Read latency is variable. A response pushed at edge M gives `Out_Valid`=1 after edge M+1 at the earliest, provided the serializer is idle.
- With `Out_Ready`=1, no wait states, and slave latency ≤ `FIFO_DEPTH` cycles, sustained output is one byte per cycle, i.e. 3 cycles per pixel.
- Outstanding reads never exceed `FIFO_DEPTH`.
- `Done` rises the cycle after the final byte transfer. `Busy` falls on the same edge.

## Test plan
- Test 1 (`FRAME_PIXELS`=4, `BASE_ADDR`=0x100, zero-wait slave, 2-cycle latency, `Out_Ready`=1):
  - Stimulus: memory {0x112233, 0x445566, 0x778899, 0xAABBCC}.
  - Required: addresses 0x100–0x103 each requested once; output bytes 11 22 33 44 55 66 77 88 99 AA BB CC; `Done`=1 one cycle after byte CC.
- Test 2 (backpressure, `FIFO_DEPTH`=4, `Out_Ready`=0 for 50 cycles):
  - Required: exactly 4 requests issued; no FIFO overflow; `Out_Byte` stays 0x11 with `Out_Valid` held. After release, all 12 bytes arrive in order.
- Test 3 (wait states, `Avm_WaitRequest` high 3 cycles on each request):
  - Required: address and `Avm_Read_N` held stable while stalled; no duplicate or skipped addresses.
- Test 4 (`Start` pulsed again while busy, then again in DONE):
  - Required: the mid-frame `Start` is ignored. The `Start` in DONE clears `Done` and re-reads from `BASE_ADDR`.
- Test 5 (`Reset` low after 5 bytes emitted):
  - Required: all outputs at reset values that cycle. A late `Avm_ReadDataValid` in IDLE is discarded. A subsequent `Start` produces a full correct frame.

Source files
------------

// File: rtl/frame_readback_reader.sv
// frame_readback_reader
//   Avalon-MM read master that fetches FRAME_PIXELS consecutive 24-bit pixels
//   from SDRAM starting at BASE_ADDR. The pixels go through a small FIFO and
//   are streamed out as bytes (R, G, B) on a valid/ready interface.
//
// Ports
//   SDRAM_CLK, Reset     clock; asynchronous active-low reset
//   Start                one-cycle request to begin readback (IDLE/DONE only)
//   Avm_*                Avalon-MM read master (chip select, address, read_n,
//                        byte enables, wait request, read data, data valid)
//   Out_Byte/Valid/Ready byte stream to the host link
//   Busy, Done           status: Busy in READ/DRAIN, Done held in DONE
module frame_readback_reader #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        SDRAM_CLK,
    input  logic        Reset,
    input  logic        Start,
    output logic        Avm_ChipSelect,
    output logic [24:0] Avm_Address,
    output logic        Avm_Read_N,
    output logic [3:0]  Avm_ByteEnable_N,
    input  logic        Avm_WaitRequest,
    input  logic [23:0] Avm_ReadData,
    input  logic        Avm_ReadDataValid,
    output logic [7:0]  Out_Byte,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [18:0]   PIX_TOTAL = 19'(FRAME_PIXELS);
    localparam logic [18:0]   LAST_PIX  = 19'(FRAME_PIXELS - 1);
    localparam logic [24:0]   BASE      = 25'(BASE_ADDR);
    localparam logic [CW-1:0] CAP       = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [24:0]   addr;
    logic [18:0]   req_cnt;
    logic [18:0]   out_cnt;
    logic [CW-1:0] credit;

    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic [23:0]   pix;
    logic [1:0]    byte_sel;
    logic          out_valid;

    logic active, start_ok, req, acc, push, xfer, last_byte, pop;

    always_comb begin
        active    = (state == S_READ) || (state == S_DRAIN);
        start_ok  = Start && ((state == S_IDLE) || (state == S_DONE));
        // credit counts outstanding reads plus FIFO occupancy, so a request
        // is only issued when its response is guaranteed a FIFO slot
        req       = (state == S_READ) && (req_cnt < PIX_TOTAL) && (credit < CAP);
        acc       = req && !Avm_WaitRequest;
        push      = active && Avm_ReadDataValid;
        xfer      = out_valid && Out_Ready;
        last_byte = xfer && (byte_sel == 2'd2);
        // serializer reloads when idle or on the cycle its B byte leaves
        pop       = active && (fifo_cnt != '0) && (!out_valid || last_byte);
    end

    always_ff @(posedge SDRAM_CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            addr      <= BASE;
            req_cnt   <= '0;
            out_cnt   <= '0;
            credit    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            pix       <= '0;
            byte_sel  <= '0;
            out_valid <= 1'b0;
        end else if (start_ok) begin
            state     <= S_READ;
            addr      <= BASE;
            req_cnt   <= '0;
            out_cnt   <= '0;
            credit    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            pix       <= '0;
            byte_sel  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (acc) begin
                addr    <= addr + 25'd1;
                req_cnt <= req_cnt + 19'd1;
                if (req_cnt == LAST_PIX) begin
                    state <= S_DRAIN;
                end
            end

            case ({acc, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (pop) begin
                pix       <= fifo_mem[rd_ptr];
                byte_sel  <= '0;
                out_valid <= 1'b1;
            end else if (xfer) begin
                if (byte_sel == 2'd2) begin
                    byte_sel  <= '0;
                    out_valid <= 1'b0;
                end else begin
                    byte_sel <= byte_sel + 2'd1;
                end
            end

            if (last_byte) begin
                out_cnt <= out_cnt + 19'd1;
                if ((state == S_DRAIN) && (out_cnt == LAST_PIX)) begin
                    state <= S_DONE;
                end
            end
        end
    end

    always_ff @(posedge SDRAM_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= Avm_ReadData;
        end
    end

    always_comb begin
        case (byte_sel)
            2'd0:    Out_Byte = pix[23:16];
            2'd1:    Out_Byte = pix[15:8];
            default: Out_Byte = pix[7:0];
        endcase
    end

    assign Avm_ChipSelect   = active;
    assign Avm_Address      = addr;
    assign Avm_Read_N       = !req;
    assign Avm_ByteEnable_N = 4'b1000;
    assign Out_Valid        = out_valid;
    assign Busy             = active;
    assign Done             = (state == S_DONE);

endmodule

// File: tb/tb_frame_readback_reader.sv
// tb_frame_readback_reader
//   Directed bench for frame_readback_reader with a 4-pixel frame at 0x100
//   and a 4-entry FIFO. A negedge process models the SDRAM slave (fixed
//   2-cycle latency, optional 3-cycle wait states) and the byte sink, and
//   logs requests and bytes; the initial block runs the tests and checks.
module tb_frame_readback_reader;

    logic        SDRAM_CLK;
    logic        Reset;
    logic        Start;
    logic        Avm_ChipSelect;
    logic [24:0] Avm_Address;
    logic        Avm_Read_N;
    logic [3:0]  Avm_ByteEnable_N;
    logic        Avm_WaitRequest;
    logic [23:0] Avm_ReadData;
    logic        Avm_ReadDataValid;
    logic [7:0]  Out_Byte;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Busy;
    logic        Done;

    frame_readback_reader #(
        .FRAME_PIXELS(4),
        .BASE_ADDR   (32'h100),
        .FIFO_DEPTH  (4)
    ) dut (
        .SDRAM_CLK        (SDRAM_CLK),
        .Reset            (Reset),
        .Start            (Start),
        .Avm_ChipSelect   (Avm_ChipSelect),
        .Avm_Address      (Avm_Address),
        .Avm_Read_N       (Avm_Read_N),
        .Avm_ByteEnable_N (Avm_ByteEnable_N),
        .Avm_WaitRequest  (Avm_WaitRequest),
        .Avm_ReadData     (Avm_ReadData),
        .Avm_ReadDataValid(Avm_ReadDataValid),
        .Out_Byte         (Out_Byte),
        .Out_Valid        (Out_Valid),
        .Out_Ready        (Out_Ready),
        .Busy             (Busy),
        .Done             (Done)
    );

    initial SDRAM_CLK = 1'b0;
    always #5 SDRAM_CLK = ~SDRAM_CLK;

    typedef struct {
        logic [23:0] d;
        int          due;
    } rsp_t;

    logic [23:0] pix_mem [4];
    logic [7:0]  exp_bytes [12];

    rsp_t        rq[$];
    logic [24:0] req_q[$];
    logic [7:0]  byte_q[$];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   outstanding = 0;
    int   max_out = 0;
    int   bad_addr = 0;
    int   stall_err = 0;
    int   stall_cycles = 0;
    int   hold_err = 0;
    int   last_xfer = -100;
    int   done_rise = -200;
    int   stall_n = 0;
    int   inj_cnt = 0;
    logic ready_en = 1'b1;
    logic wait_mode = 1'b0;
    logic stalled_prev = 1'b0;
    logic [24:0] stall_addr = '0;
    logic done_prev = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [7:0] prev_byte = '0;

    initial begin
        Avm_WaitRequest   = 1'b0;
        Avm_ReadData      = '0;
        Avm_ReadDataValid = 1'b0;
        Out_Ready         = 1'b1;
    end

    // slave + sink model; decisions made at negedge take effect at the next posedge
    always @(negedge SDRAM_CLK) begin
        logic [24:0] idx;
        logic        wr;
        rsp_t        r;
        cyc = cyc + 1;

        if (stalled_prev && (Avm_Read_N !== 1'b0 || Avm_Address !== stall_addr))
            stall_err = stall_err + 1;
        if (prev_valid && !prev_ready && (Out_Valid !== 1'b1 || Out_Byte !== prev_byte))
            hold_err = hold_err + 1;

        if (inj_cnt > 0) begin
            inj_cnt = inj_cnt - 1;
            Avm_ReadDataValid <= 1'b1;
            Avm_ReadData      <= 24'hDEADBE;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            Avm_ReadDataValid <= 1'b1;
            Avm_ReadData      <= rq[0].d;
            void'(rq.pop_front());
            outstanding = outstanding - 1;
        end else begin
            Avm_ReadDataValid <= 1'b0;
        end

        wr = 1'b0;
        if (Avm_Read_N === 1'b0 && Avm_ChipSelect === 1'b1) begin
            if (wait_mode && stall_n < 3) begin
                wr = 1'b1;
                stall_n = stall_n + 1;
                stall_cycles = stall_cycles + 1;
            end else begin
                stall_n = 0;
                req_q.push_back(Avm_Address);
                idx = Avm_Address - 25'h100;
                r.d = 24'h0;
                if (idx < 25'd4) r.d = pix_mem[idx[1:0]];
                else bad_addr = bad_addr + 1;
                r.due = cyc + 2;
                rq.push_back(r);
                outstanding = outstanding + 1;
                if (outstanding > max_out) max_out = outstanding;
            end
        end else begin
            stall_n = 0;
        end
        Avm_WaitRequest <= wr;
        stalled_prev = (Avm_Read_N === 1'b0) && wr;
        stall_addr   = Avm_Address;

        Out_Ready <= ready_en;
        if (Out_Valid === 1'b1 && ready_en) begin
            byte_q.push_back(Out_Byte);
            last_xfer = cyc;
        end
        prev_valid = Out_Valid;
        prev_ready = ready_en;
        prev_byte  = Out_Byte;

        if (Done === 1'b1 && !done_prev) done_rise = cyc;
        done_prev = Done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        byte_q.delete();
        max_out      = outstanding;
        bad_addr     = 0;
        stall_err    = 0;
        stall_cycles = 0;
        hold_err     = 0;
        last_xfer    = -100;
        done_rise    = -200;
    endtask

    task automatic pulse_start();
        @(negedge SDRAM_CLK);
        Start = 1'b1;
        @(negedge SDRAM_CLK);
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (Done !== 1'b1 && n < budget) begin
            @(negedge SDRAM_CLK);
            n = n + 1;
        end
        chk({tag, "_done_timeout"}, {31'd0, Done}, 32'd1);
        @(negedge SDRAM_CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs"},    {31'd0, Avm_ChipSelect}, 32'd0);
        chk({tag, "_addr"},  {7'd0, Avm_Address}, 32'h100);
        chk({tag, "_readn"}, {31'd0, Avm_Read_N}, 32'd1);
        chk({tag, "_be"},    {28'd0, Avm_ByteEnable_N}, 32'h8);
        chk({tag, "_valid"}, {31'd0, Out_Valid}, 32'd0);
        chk({tag, "_byte"},  {24'd0, Out_Byte}, 32'd0);
        chk({tag, "_busy"},  {31'd0, Busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, Done}, 32'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nreq"}, req_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_req%0d", tag, i),
                (i < req_q.size()) ? {7'd0, req_q[i]} : 32'hFFFF_FFFF, 32'h100 + i);
        chk({tag, "_nbytes"}, byte_q.size(), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_bytes[i]});
        chk({tag, "_bad_addr"}, bad_addr, 32'd0);
        chk({tag, "_max_outstanding_le4"}, {31'd0, (max_out <= 4)}, 32'd1);
        chk({tag, "_hold"}, hold_err, 32'd0);
        chk({tag, "_done_delay"}, done_rise - last_xfer, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int n;
        pix_mem   = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                      8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        Reset = 1'b0;
        Start = 1'b0;
        repeat (3) @(negedge SDRAM_CLK);
        check_reset_outputs("rst");
        Reset = 1'b1;
        @(negedge SDRAM_CLK);

        // Test 1: basic frame
        clear_logs();
        pulse_start();
        chk("t1_busy_after_start", {31'd0, Busy}, 32'd1);
        chk("t1_first_readn", {31'd0, Avm_Read_N}, 32'd0);
        wait_done("t1", 200);
        check_frame("t1");

        // Test 2: sink backpressure for 50 cycles
        clear_logs();
        ready_en = 1'b0;
        pulse_start();
        repeat (50) @(negedge SDRAM_CLK);
        chk("t2_nreq_stalled", req_q.size(), 32'd4);
        chk("t2_valid_held", {31'd0, Out_Valid}, 32'd1);
        chk("t2_byte_held", {24'd0, Out_Byte}, 32'h11);
        chk("t2_no_bytes", byte_q.size(), 32'd0);
        chk("t2_hold_during", hold_err, 32'd0);
        ready_en = 1'b1;
        wait_done("t2", 200);
        check_frame("t2");

        // Test 3: three wait states per request
        clear_logs();
        wait_mode = 1'b1;
        pulse_start();
        wait_done("t3", 400);
        check_frame("t3");
        chk("t3_stall_stable", stall_err, 32'd0);
        chk("t3_stall_cycles", stall_cycles, 32'd12);
        wait_mode = 1'b0;

        // Test 4: Start while busy is ignored; Start in DONE restarts
        clear_logs();
        pulse_start();
        repeat (5) @(negedge SDRAM_CLK);
        pulse_start();
        wait_done("t4a", 200);
        check_frame("t4a");
        clear_logs();
        pulse_start();
        chk("t4b_done_cleared", {31'd0, Done}, 32'd0);
        chk("t4b_busy", {31'd0, Busy}, 32'd1);
        chk("t4b_addr_base", {7'd0, Avm_Address}, 32'h100);
        wait_done("t4b", 200);
        check_frame("t4b");

        // Test 5: reset mid-frame, stray response in IDLE, then a clean frame
        clear_logs();
        pulse_start();
        n = 0;
        while (byte_q.size() < 5 && n < 100) begin
            @(negedge SDRAM_CLK);
            n = n + 1;
        end
        chk("t5_five_bytes", {31'd0, (byte_q.size() >= 5)}, 32'd1);
        Reset = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        repeat (2) @(negedge SDRAM_CLK);
        Reset = 1'b1;
        n = 0;
        while (rq.size() > 0 && n < 20) begin
            @(negedge SDRAM_CLK);
            n = n + 1;
        end
        @(negedge SDRAM_CLK);
        inj_cnt = 1;
        repeat (4) @(negedge SDRAM_CLK);
        chk("t5_idle_valid", {31'd0, Out_Valid}, 32'd0);
        chk("t5_idle_busy", {31'd0, Busy}, 32'd0);
        clear_logs();
        pulse_start();
        wait_done("t5", 200);
        check_frame("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
